// File: rtl/mem_copy_engine.sv
// +-----------------------------------------------------------------------+
// | mem_copy_engine: block-copy DMA master for a single-port sync memory   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_copy_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] src_ptr, src_next;
  logic [ADDR_WIDTH-1:0] dst_ptr, dst_next;
  logic [LEN_WIDTH-1:0]  remaining, remaining_next;
  logic [LEN_WIDTH-1:0]  words_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  busy_next, done_next, rd_next, wr_next;

  // Outputs are computed for the state being entered, so every output is a flop.
  always_comb begin
    state_next     = state;
    src_next       = src_ptr;
    dst_next       = dst_ptr;
    remaining_next = remaining;
    words_next     = words_done;
    data_next      = mem_data_in;
    addr_next      = mem_address;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    rd_next        = 1'b0;
    wr_next        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          src_next       = src_addr;
          dst_next       = dst_addr;
          remaining_next = length;
          words_next     = '0;
          if (length == '0) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = S_READ;
            busy_next  = 1'b1;
            rd_next    = 1'b1;
            addr_next  = src_addr;
          end
        end
      end
      S_READ: begin
        state_next = S_WAIT;
        busy_next  = 1'b1;
      end
      S_WAIT: begin
        // Read data is valid this cycle; it becomes the write data directly.
        state_next = S_WRITE;
        busy_next  = 1'b1;
        wr_next    = 1'b1;
        addr_next  = dst_ptr;
        data_next  = mem_data_out;
      end
      S_WRITE: begin
        src_next       = src_ptr + ADDR_WIDTH'(1);
        dst_next       = dst_ptr + ADDR_WIDTH'(1);
        words_next     = words_done + LEN_WIDTH'(1);
        remaining_next = remaining - LEN_WIDTH'(1);
        if (remaining == LEN_WIDTH'(1)) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end else begin
          state_next = S_READ;
          busy_next  = 1'b1;
          rd_next    = 1'b1;
          addr_next  = src_ptr + ADDR_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      src_ptr          <= '0;
      dst_ptr          <= '0;
      remaining        <= '0;
      words_done       <= '0;
      mem_data_in      <= '0;
      mem_address      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
    end else begin
      state            <= state_next;
      src_ptr          <= src_next;
      dst_ptr          <= dst_next;
      remaining        <= remaining_next;
      words_done       <= words_next;
      mem_data_in      <= data_next;
      mem_address      <= addr_next;
      busy             <= busy_next;
      done             <= done_next;
      mem_read_enable  <= rd_next;
      mem_write_enable <= wr_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// +-----------------------------------------------------------------------+
// | tb_mem_copy_engine: scoreboard bench with a behavioural copy model     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_mem_copy_engine;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done;
  logic [LW-1:0] words_done;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          mem_write_enable, mem_read_enable;

  mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .words_done(words_done),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory under test; the bench's own port preloads it while the engine is idle.
  logic [DW-1:0] mem [0:255];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_a = '0;
  logic [DW-1:0] tb_d = '0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_a] <= tb_d;
    else if (mem_write_enable) mem[mem_address] <= mem_data_in;
    if (mem_read_enable) mem_data_out <= mem[mem_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xact_t;
  typedef struct {
    int cyc;
    int words;
  } dn_t;

  xact_t         rdq[$];
  xact_t         wrq[$];
  dn_t           doneq[$];
  logic [DW-1:0] ref_mem [0:255];
  int            busy_lo = 0;
  int            busy_hi = -1;
  bit            mon_on = 1'b0;
  int            passed = 0;
  int            total = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the expected access/completion whenever the DUT presents one.
  xact_t mx;
  dn_t   md;
  always @(negedge clk) begin
    if (mon_on) begin
      check(busy === ((cyc >= busy_lo) && (cyc <= busy_hi)), "busy", longint'(busy),
            longint'((cyc >= busy_lo) && (cyc <= busy_hi)));
      if (mem_read_enable || mem_write_enable)
        check(!(mem_read_enable && mem_write_enable), "strobe_excl",
              longint'({mem_read_enable, mem_write_enable}), 0);
      if (mem_read_enable) begin
        if (rdq.size() == 0) check(1'b0, "unexpected_read", longint'(mem_address), 0);
        else begin
          mx = rdq.pop_front();
          check(cyc == mx.cyc, "read_cycle", longint'(cyc), longint'(mx.cyc));
          check(mem_address === mx.addr, "read_addr", longint'(mem_address), longint'(mx.addr));
        end
      end
      if (mem_write_enable) begin
        if (wrq.size() == 0) check(1'b0, "unexpected_write", longint'(mem_address), 0);
        else begin
          mx = wrq.pop_front();
          check(cyc == mx.cyc, "write_cycle", longint'(cyc), longint'(mx.cyc));
          check(mem_address === mx.addr, "write_addr", longint'(mem_address), longint'(mx.addr));
          check(mem_data_in === mx.data, "write_data", longint'(mem_data_in), longint'(mx.data));
        end
      end
      if (done) begin
        if (doneq.size() == 0) check(1'b0, "unexpected_done", longint'(cyc), 0);
        else begin
          md = doneq.pop_front();
          check(cyc == md.cyc, "done_cycle", longint'(cyc), longint'(md.cyc));
          check(words_done === LW'(md.words), "done_words", longint'(words_done), longint'(md.words));
        end
      end
    end
  end

  // Reference: copy word by word in ascending order, wrapping addresses.
  task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                       input int base, input int nrd, input int nwr, input bit with_done);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] sa, da;
      xact_t x;
      sa = s + AW'(i);
      da = d + AW'(i);
      if (i < nrd) begin
        x.cyc = base + 3 * i; x.addr = sa; x.data = '0;
        rdq.push_back(x);
      end
      if (i < nwr) begin
        ref_mem[da] = ref_mem[sa];
        x.cyc = base + 3 * i + 2; x.addr = da; x.data = ref_mem[da];
        wrq.push_back(x);
      end
    end
    if (with_done) begin
      dn_t dd;
      dd.cyc = base + 3 * n; dd.words = n;
      doneq.push_back(dd);
    end
  endtask

  task automatic check_reset_outs(input string name);
    check(busy === 1'b0 && done === 1'b0 && mem_read_enable === 1'b0 && mem_write_enable === 1'b0
          && mem_address === '0 && mem_data_in === '0 && words_done === '0, name,
          longint'({busy, done, mem_read_enable, mem_write_enable, mem_address, mem_data_in, words_done}), 0);
  endtask

  task automatic poke_mem(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    tb_we = 1'b1; tb_a = a; tb_d = v;
    ref_mem[a] = v;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // poke: cycle in which a stray start (src=0x40) is raised; abort: cycle in which rst_n is low.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                          input int poke, input int abort);
    int base, last, nrd, nwr;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; length = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc;
    if (abort > 0) begin
      nrd = (abort + 2) / 3; if (nrd > n) nrd = n;
      nwr = abort / 3;       if (nwr > n) nwr = n;
      model(s, d, n, base, nrd, nwr, 1'b0);
      busy_lo = base; busy_hi = base + abort - 1;
      last = abort + 2;
    end else begin
      model(s, d, n, base, n, n, 1'b1);
      busy_lo = base; busy_hi = base + 3 * n - 1;
      last = 3 * n + 3;
    end
    for (int k = 1; k <= last; k++) begin
      start = (k == poke);
      if (k == poke) begin
        src_addr = 8'h40; dst_addr = 8'hC0; length = LW'(7);
      end
      rst_n = !(abort > 0 && k == abort);
      if (abort > 0 && k == abort + 1) check_reset_outs("abort_outputs");
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst_n = 1'b1;
    check(rdq.size() == 0 && wrq.size() == 0 && doneq.size() == 0, "queues_drained",
          longint'(rdq.size() + wrq.size() + doneq.size()), 0);
    if (abort == 0) check(words_done === LW'(n), "words_done_hold", longint'(words_done), longint'(n));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; src_addr = 8'h12; dst_addr = 8'h34; length = LW'(5);
    @(posedge clk); #1;
    mon_on = 1'b1;
    check_reset_outs("reset_outputs_1");
    @(posedge clk); #1;
    check_reset_outs("reset_outputs_2");
    start = 1'b0; rst_n = 1'b1;

    for (int i = 0; i < 256; i++) poke_mem(AW'(i), DW'($urandom));

    poke_mem(8'h00, 16'h1234);
    run_copy(8'h00, 8'h10, 1, 0, 0);
    check(mem[8'h10] === 16'h1234, "single_word_mem", longint'(mem[8'h10]), 64'h1234);

    poke_mem(8'hFE, 16'hABCD);
    poke_mem(8'hFF, 16'h5555);
    poke_mem(8'h00, 16'h0001);
    run_copy(8'hFE, 8'h80, 3, 0, 0);
    check({mem[8'h80], mem[8'h81], mem[8'h82]} === {16'hABCD, 16'h5555, 16'h0001}, "wrap_mem",
          longint'({mem[8'h80], mem[8'h81], mem[8'h82]}), 64'hABCD55550001);

    run_copy(8'h33, 8'h44, 0, 0, 0);
    run_copy(8'h20, 8'h30, 4, 2, 0);
    run_copy(8'h50, 8'h58, 2, 7, 0);
    run_copy(8'h00, 8'h50, 4, 0, 5);
    run_copy(8'h70, 8'h90, 2, 0, 0);
    run_copy(8'h60, 8'h62, 5, 0, 0);

    for (int r = 0; r < 15; r++) begin
      int n, p;
      n = $urandom_range(0, 12);
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * n + 1) : 0;
      run_copy(AW'($urandom), AW'($urandom), n, p, 0);
    end

    run_copy(8'h10, 8'h11, 256, 0, 0);

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      check(bad == 0, "final_memory_words_differing", longint'(bad), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
